// File: rtl/shift_reg_multimode.sv
// rtl/shift_reg_multimode.sv - multi-mode shift register with burst start/busy/done handshake
// Optional SHREG_PARITY_EN adds a registered XOR-parity of q on the parity port.
module shift_reg_multimode #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       sel,
   input  logic [CNT_W-1:0] count,
   input  logic             en,
   input  logic             sin,
   input  logic [WIDTH-1:0] pdata,
   output logic [WIDTH-1:0] q,
   output logic             sout_r,
   output logic             sout_l,
   output logic             busy,
   output logic             done,
   output logic             parity
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   localparam logic [2:0] OP_SHR  = 3'b000;
   localparam logic [2:0] OP_SHL  = 3'b001;
   localparam logic [2:0] OP_LOAD = 3'b010;
   localparam logic [2:0] OP_ROR  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;
   localparam logic [2:0] OP_ASR  = 3'b101;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [2:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   function automatic logic [WIDTH-1:0] step_f(input logic [2:0] op,
                                               input logic [WIDTH-1:0] v,
                                               input logic s);
      logic [WIDTH-1:0] r;
      case (op)
         OP_SHR:  r = {s, v[WIDTH-1:1]};
         OP_SHL:  r = {v[WIDTH-2:0], s};
         OP_ROR:  r = {v[0], v[WIDTH-1:1]};
         OP_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
         OP_ASR:  r = {v[WIDTH-1], v[WIDTH-1:1]};
         default: r = v;
      endcase
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               // Load, hold codes and zero-length bursts all complete in one edge
               if (sel == OP_LOAD) begin
                  q_d     = pdata;
                  state_d = S_DONE;
               end else if (sel[2:1] == 2'b11 || count == '0) begin
                  state_d = S_DONE;
               end else begin
                  op_d    = sel;
                  cnt_d   = count;
                  state_d = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            if (en) begin
               q_d   = step_f(op_q, q_q, sin);
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         q_q     <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   assign q      = q_q;
   assign sout_r = q_q[0];
   assign sout_l = q_q[WIDTH-1];
   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);

`ifdef SHREG_PARITY_EN
   logic parity_q, parity_d;

   // ^q_d equals ^q_q on edges that leave q unchanged, so updating every edge is equivalent
   always_comb parity_d = ^q_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) parity_q <= 1'b0;
      else        parity_q <= parity_d;
   end

   assign parity = parity_q;
`else
   assign parity = 1'b0;
`endif

endmodule
